// File: rtl/game_pkg.sv
// Shared types and helpers for the flappy game sequencer: FSM state codes,
// 2-digit BCD score type and its saturating increment / magnitude compare.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        RUN       = 3'd2,
        PAUSE     = 3'd3,
        DYING     = 3'd4,
        OVER      = 3'd5
    } state_t;

    typedef logic [7:0] bcd2_t;

    localparam int CD_DIGITS_DEF       = 3;
    localparam int TICKS_PER_DIGIT_DEF = 5;
    localparam int DYING_TICKS_DEF     = 10;
    localparam int OVER_HOLD_TICKS_DEF = 5;

    function automatic bcd2_t bcd2_inc_sat(input bcd2_t v);
        if (v == 8'h99)
            return v;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic bcd2_gt(input bcd2_t a, input bcd2_t b);
        if (a[7:4] != b[7:4])
            return a[7:4] > b[7:4];
        return a[3:0] > b[3:0];
    endfunction

endpackage

// File: rtl/game_sync_edge.sv
// 2-flop synchroniser plus a history flop; gives the clean level, its rising
// edge and a toggle event. All three flops reset to RST_PREV.
module sync_edge #(
    parameter logic RST_PREV = 1'b0
) (
    input  logic clk_5Hz,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic toggle
);
    logic s1, s2, prev;

    // Seeding the whole chain with RST_PREV means a button held through reset
    // looks "already pressed" and never produces a spurious rise.
    always_ff @(posedge clk_5Hz or posedge rst) begin
        if (rst) begin
            s1   <= RST_PREV;
            s2   <= RST_PREV;
            prev <= RST_PREV;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign level  = s2;
    assign rise   = s2 & ~prev;
    assign toggle = s2 ^ prev;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: IDLE -> COUNTDOWN -> RUN <-> PAUSE -> DYING -> OVER -> IDLE,
// driving the bird/pipe datapath controls and tracking score / high score in BCD.
module game_ctrl
    import game_pkg::*;
#(
    parameter int CD_DIGITS       = CD_DIGITS_DEF,
    parameter int TICKS_PER_DIGIT = TICKS_PER_DIGIT_DEF,
    parameter int DYING_TICKS     = DYING_TICKS_DEF,
    parameter int OVER_HOLD_TICKS = OVER_HOLD_TICKS_DEF
) (
    input  logic       clk_5Hz,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       collision,
    input  logic       bruin_game_over,
    input  logic       pipe_pass_tgl,
    output logic       game_start,
    output logic       lose,
    output logic       game_rst,
    output logic [2:0] state,
    output logic [1:0] countdown,
    output logic [7:0] score_bcd,
    output logic [7:0] high_bcd,
    output logic       new_high
);
    localparam int          NUM_IN    = 5;
    localparam int          I_START   = 0;
    localparam int          I_PAUSE   = 1;
    localparam int          I_COLL    = 2;
    localparam int          I_FLOOR   = 3;
    localparam int          I_PIPE    = 4;
    localparam logic [4:0]  RST_MASK  = 5'b00011;
    localparam logic [1:0]  CD_INIT   = 2'(CD_DIGITS);
    localparam logic [7:0]  CD_LAST   = 8'(TICKS_PER_DIGIT - 1);
    localparam logic [7:0]  DIE_LAST  = 8'(DYING_TICKS - 1);
    localparam logic [7:0]  HOLD_CNT  = 8'(OVER_HOLD_TICKS);

    logic [NUM_IN-1:0] din, lvl, rise, tgl;
    assign din = {pipe_pass_tgl, bruin_game_over, collision, btn_pause, btn_start};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_sync
        sync_edge #(.RST_PREV(RST_MASK[i])) u_sync (
            .clk_5Hz (clk_5Hz),
            .rst     (rst),
            .din     (din[i]),
            .level   (lvl[i]),
            .rise    (rise[i]),
            .toggle  (tgl[i])
        );
    end

    logic start_rise, pause_rise, death, pipe_evt;
    assign start_rise = rise[I_START];
    assign pause_rise = rise[I_PAUSE];
    assign death      = lvl[I_COLL] | lvl[I_FLOOR];
    assign pipe_evt   = tgl[I_PIPE];

    logic unused;
    assign unused = ^{lvl[I_START], lvl[I_PAUSE], lvl[I_PIPE], rise[4:2], tgl[3:0]};

    state_t     cur, nxt;
    logic [7:0] cnt;
    logic       cd_wrap, hold_done;

    assign cd_wrap   = (cnt == CD_LAST);
    assign hold_done = (cnt >= HOLD_CNT);
    assign state     = cur;

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:      if (start_rise) nxt = COUNTDOWN;
            COUNTDOWN: if (cd_wrap && countdown == 2'd1) nxt = RUN;
            RUN: begin
                if (death)           nxt = DYING;
                else if (pause_rise) nxt = PAUSE;
            end
            PAUSE:     if (pause_rise || start_rise) nxt = RUN;
            DYING:     if (cnt == DIE_LAST) nxt = OVER;
            OVER:      if (hold_done && start_rise) nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_5Hz or posedge rst) begin
        if (rst) begin
            cur        <= IDLE;
            cnt        <= '0;
            game_start <= 1'b0;
            lose       <= 1'b0;
            game_rst   <= 1'b0;
            countdown  <= '0;
            score_bcd  <= '0;
            high_bcd   <= '0;
            new_high   <= 1'b0;
        end else begin
            cur        <= nxt;
            game_start <= (nxt == RUN) || (nxt == DYING);
            lose       <= (nxt == DYING) || (nxt == OVER);
            game_rst   <= 1'b0;
            case (cur)
                IDLE: if (nxt == COUNTDOWN) begin
                    countdown <= CD_INIT;
                    cnt       <= '0;
                    score_bcd <= '0;
                    new_high  <= 1'b0;
                    game_rst  <= 1'b1;
                end
                COUNTDOWN: begin
                    if (cd_wrap) begin
                        cnt       <= '0;
                        countdown <= countdown - 2'd1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                // death and pause outrank a same-cycle pipe event
                RUN: begin
                    if (nxt == DYING)
                        cnt <= '0;
                    else if (nxt == RUN && pipe_evt)
                        score_bcd <= bcd2_inc_sat(score_bcd);
                end
                DYING: begin
                    if (nxt == OVER) begin
                        cnt <= '0;
                        if (bcd2_gt(score_bcd, high_bcd)) begin
                            high_bcd <= score_bcd;
                            new_high <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                OVER: begin
                    if (nxt == IDLE)
                        game_rst <= 1'b1;
                    else if (!hold_done)
                        cnt <= cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboarded bench for game_ctrl: expected scores are queued when pipe events
// are driven and popped whenever score_bcd changes.
module tb_game_ctrl;
    logic       clk_5Hz = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0, btn_pause = 1'b0, collision = 1'b0;
    logic       bruin_game_over = 1'b0, pipe_pass_tgl = 1'b0;
    logic       game_start, lose, game_rst, new_high;
    logic [2:0] state;
    logic [1:0] countdown;
    logic [7:0] score_bcd, high_bcd;

    int         n_chk = 0, n_pass = 0;
    int         model_n = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_score = 8'h00;
    bit         mon_en = 1'b0;

    localparam logic [2:0] S_IDLE = 3'd0, S_CD = 3'd1, S_RUN = 3'd2,
                           S_PAUSE = 3'd3, S_DYING = 3'd4, S_OVER = 3'd5;

    game_ctrl dut (
        .clk_5Hz(clk_5Hz), .rst(rst), .btn_start(btn_start), .btn_pause(btn_pause),
        .collision(collision), .bruin_game_over(bruin_game_over),
        .pipe_pass_tgl(pipe_pass_tgl), .game_start(game_start), .lose(lose),
        .game_rst(game_rst), .state(state), .countdown(countdown),
        .score_bcd(score_bcd), .high_bcd(high_bcd), .new_high(new_high)
    );

    always #5 clk_5Hz = ~clk_5Hz;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_5Hz);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        return 8'((n / 10) * 16 + (n % 10));
    endfunction

    // scoreboard monitor: every score change must match the next queued value
    always @(posedge clk_5Hz) begin
        #1;
        if (score_bcd !== last_score) begin
            if (mon_en) begin
                if (exp_q.size() == 0) chk("sb_spurious", 16'(score_bcd), 16'(last_score));
                else chk("sb_score", 16'(score_bcd), 16'(exp_q.pop_front()));
            end
            last_score = score_bcd;
        end
    end

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (state !== s && n < budget) begin
            tick(1);
            n++;
        end
        chk("wait_state", 16'(state), 16'(s));
    endtask

    task automatic pipe(input bit scoring);
        pipe_pass_tgl = ~pipe_pass_tgl;
        if (scoring && model_n < 99) begin
            model_n++;
            exp_q.push_back(to_bcd(model_n));
        end
        tick(2);
    endtask

    task automatic drain_check();
        tick(4);
        chk("sb_drain", 16'(exp_q.size()), 16'd0);
    endtask

    task automatic start_game();
        mon_en = 1'b0;
        btn_start = 1'b1;
        tick(3);
        chk("start_grst", 16'(game_rst), 16'd1);
        btn_start = 1'b0;
        wait_state(S_RUN, 20);
        model_n = 0;
        mon_en = 1'b1;
    endtask

    task automatic leave_over();
        btn_start = 1'b1;
        tick(3);
        chk("over_exit", 16'(state), 16'(S_IDLE));
        chk("over_grst", 16'(game_rst), 16'd1);
        tick(1);
        chk("over_grst_end", 16'(game_rst), 16'd0);
        btn_start = 1'b0;
        tick(3);
    endtask

    initial begin
        tick(2);
        chk("rst_state", 16'(state), 16'(S_IDLE));
        chk("rst_outs", {9'd0, game_start, lose, game_rst, countdown, 1'b0, new_high}, 16'd0);
        chk("rst_bcd", {score_bcd, high_bcd}, 16'd0);
        #2 rst = 1'b0;
        tick(2);

        // game 1: detailed countdown
        btn_start = 1'b1;
        tick(3);
        chk("cd_entry", 16'(state), 16'(S_CD));
        chk("cd_grst", 16'(game_rst), 16'd1);
        for (int i = 0; i < 15; i++) begin
            if (i > 0) tick(1);
            if (i == 1) chk("cd_grst_end", 16'(game_rst), 16'd0);
            if (i == 2) btn_start = 1'b0;
            chk("cd_digit", 16'(countdown), 16'(3 - i / 5));
        end
        tick(1);
        chk("run_entry", 16'(state), 16'(S_RUN));
        chk("run_go", {game_start, lose, countdown}, 16'b1000);
        model_n = 0;
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) pipe(1'b1);
        drain_check();

        // pause, pipe ignored, resume
        btn_pause = 1'b1;
        tick(3);
        chk("pause_state", 16'(state), 16'(S_PAUSE));
        chk("pause_gs", 16'(game_start), 16'd0);
        btn_pause = 1'b0;
        pipe(1'b0);
        pipe(1'b0);
        tick(2);
        btn_pause = 1'b1;
        tick(3);
        chk("resume", 16'(state), 16'(S_RUN));
        btn_pause = 1'b0;
        chk("pause_score", 16'(score_bcd), 16'h05);

        // collision together with a pipe event: death wins
        collision = 1'b1;
        pipe_pass_tgl = ~pipe_pass_tgl;
        tick(3);
        chk("dying_entry", 16'(state), 16'(S_DYING));
        collision = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick(1);
            chk("dying_lose", {state, game_start, lose}, {S_DYING, 2'b11});
        end
        tick(1);
        chk("over_entry", {state, game_start, lose}, {S_OVER, 2'b01});
        chk("over_high", {high_bcd, 7'd0, new_high}, {8'h05, 8'h01});
        btn_start = 1'b1;
        tick(4);
        btn_start = 1'b0;
        chk("over_hold", 16'(state), 16'(S_OVER));
        tick(4);
        leave_over();

        // game 2: score 3 < high 5
        start_game();
        for (int i = 0; i < 3; i++) pipe(1'b1);
        drain_check();
        bruin_game_over = 1'b1;
        wait_state(S_DYING, 6);
        bruin_game_over = 1'b0;
        wait_state(S_OVER, 15);
        chk("g2_high", {high_bcd, 7'd0, new_high}, {8'h05, 8'h00});
        chk("g2_score", 16'(score_bcd), 16'h03);
        tick(7);
        leave_over();

        // game 3: BCD carry and saturation, then reset mid-DYING
        start_game();
        for (int i = 0; i < 12; i++) pipe(1'b1);
        drain_check();
        chk("score_12", 16'(score_bcd), 16'h12);
        for (int i = 0; i < 87; i++) pipe(1'b1);
        drain_check();
        pipe(1'b1);
        drain_check();
        chk("score_sat", 16'(score_bcd), 16'h99);
        collision = 1'b1;
        wait_state(S_DYING, 6);
        collision = 1'b0;
        tick(3);
        mon_en = 1'b0;
        btn_start = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_state", 16'(state), 16'(S_IDLE));
        chk("mid_rst_outs", {9'd0, game_start, lose, game_rst, countdown, 1'b0, new_high}, 16'd0);
        chk("mid_rst_bcd", {score_bcd, high_bcd}, 16'd0);
        #2 rst = 1'b0;
        tick(6);
        chk("held_start", 16'(state), 16'(S_IDLE));
        btn_start = 1'b0;
        tick(3);
        btn_start = 1'b1;
        tick(3);
        chk("repress", 16'(state), 16'(S_CD));
        btn_start = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
